tlul_simple_host: RTL and testbench

- Single-outstanding TL-UL initiator that turns a req/gnt/valid register-access interface into TL-UL A-channel requests and collects D-channel responses.
- It is the host side that drives tl_i into peripheral register tops such as the UART's, for use by DV-lite masters, debug bridges and small controllers.
- One transaction is in flight at a time, with response checking and error reporting.

---
 rtl/tlul_simple_host.sv | 242 ++++++++++++++++++++++++
 tb/tb_tlul_simple_host.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tlul_simple_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tlul_simple_host : single-outstanding TL-UL initiator (req/gnt -> A/D).     |
// | Optional D-channel timeout: TLUL_SIMPLE_HOST_TIMEOUT_EN.                    |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+

package tlul_pkg;
  localparam logic [2:0] PutFullData    = 3'h0;
  localparam logic [2:0] PutPartialData = 3'h1;
  localparam logic [2:0] Get            = 3'h4;
  localparam logic [2:0] AccessAck      = 3'h0;
  localparam logic [2:0] AccessAckData  = 3'h1;

  typedef struct packed {
    logic [6:0] cmd_intg;
    logic [6:0] data_intg;
  } tl_a_user_t;

  typedef struct packed {
    logic [6:0] rsp_intg;
    logic [6:0] data_intg;
  } tl_d_user_t;

  typedef struct packed {
    logic        a_valid;
    logic [2:0]  a_opcode;
    logic [2:0]  a_param;
    logic [1:0]  a_size;
    logic [7:0]  a_source;
    logic [31:0] a_address;
    logic [3:0]  a_mask;
    logic [31:0] a_data;
    tl_a_user_t  a_user;
    logic        d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic        d_valid;
    logic [2:0]  d_opcode;
    logic [2:0]  d_param;
    logic [1:0]  d_size;
    logic [7:0]  d_source;
    logic        d_sink;
    logic [31:0] d_data;
    tl_d_user_t  d_user;
    logic        d_error;
    logic        a_ready;
  } tl_d2h_t;

  // Inverted 7-bit fold code shared by command, response and data integrity.
  function automatic logic [6:0] intg7(input logic [63:0] d);
    logic [69:0] p;
    p = {6'b0, d};
    return ~(p[6:0] ^ p[13:7] ^ p[20:14] ^ p[27:21] ^ p[34:28] ^
             p[41:35] ^ p[48:42] ^ p[55:49] ^ p[62:56] ^ p[69:63]);
  endfunction

  function automatic logic [6:0] cmd_intg(input logic [2:0] op, input logic [3:0] mask,
                                          input logic [31:0] addr);
    return intg7({25'b0, op, mask, addr});
  endfunction

  function automatic logic [6:0] rsp_intg(input logic [2:0] op, input logic [1:0] size,
                                          input logic err);
    return intg7({58'b0, op, size, err});
  endfunction

  function automatic logic [6:0] data_intg(input logic [31:0] d);
    return intg7({32'b0, d});
  endfunction
endpackage

module tlul_simple_host #(
  parameter logic [7:0] SourceId       = 8'h00,
  parameter bit         AddrAlignCheck = 1'b1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [31:0]        wdata_i,
  input  logic [3:0]         be_i,
  output logic               valid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic               busy_o,
  output tlul_pkg::tl_h2d_t  tl_o,
  input  tlul_pkg::tl_d2h_t  tl_i
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    A_REQ     = 3'd1,
    D_WAIT    = 3'd2,
    RESP      = 3'd3,
    LOCAL_ERR = 3'd4
  } state_e;

  state_e      r_state;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic        r_valid;
  logic        r_err;
  logic [31:0] r_rdata;

  logic        w_misaligned;
  logic [2:0]  w_a_opcode;
  logic [3:0]  w_a_mask;
  logic [31:0] w_a_data;
  logic [2:0]  w_exp_dop;
  logic        w_rsp_err;
  logic        w_drop;
  logic        w_unused;

  assign w_misaligned = AddrAlignCheck && (addr_i[1:0] != 2'b00);
  assign gnt_o        = (r_state == IDLE) && req_i;
  assign busy_o       = (r_state != IDLE);
  assign valid_o      = r_valid;
  assign err_o        = r_err;
  assign rdata_o      = r_rdata;

  assign w_a_opcode = !r_we ? tlul_pkg::Get :
                      (r_be == 4'hF) ? tlul_pkg::PutFullData : tlul_pkg::PutPartialData;
  assign w_a_mask   = r_we ? r_be : 4'hF;
  assign w_a_data   = r_we ? r_wdata : 32'h0;
  assign w_exp_dop  = r_we ? tlul_pkg::AccessAck : tlul_pkg::AccessAckData;

  assign w_rsp_err = tl_i.d_error
                   | (tl_i.d_source != SourceId)
                   | (tl_i.d_opcode != w_exp_dop)
                   | (tl_i.d_user.rsp_intg !=
                      tlul_pkg::rsp_intg(tl_i.d_opcode, tl_i.d_size, tl_i.d_error))
                   | (tl_i.d_user.data_intg != tlul_pkg::data_intg(tl_i.d_data));

  assign w_unused = ^{tl_i.d_param, tl_i.d_sink};

  always_comb begin
    tl_o                  = '0;
    tl_o.a_valid          = (r_state == A_REQ);
    tl_o.a_opcode         = w_a_opcode;
    tl_o.a_size           = 2'd2;
    tl_o.a_source         = SourceId;
    tl_o.a_address        = {r_addr[31:2], 2'b00};
    tl_o.a_mask           = w_a_mask;
    tl_o.a_data           = w_a_data;
    tl_o.a_user.cmd_intg  = tlul_pkg::cmd_intg(w_a_opcode, w_a_mask, {r_addr[31:2], 2'b00});
    tl_o.a_user.data_intg = tlul_pkg::data_intg(w_a_data);
    tl_o.d_ready          = (r_state == D_WAIT) | w_drop;
  end

`ifdef TLUL_SIMPLE_HOST_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_drop;

  assign w_drop = r_drop && (r_state == IDLE);

  // After a timeout, keep accepting D beats in IDLE so the stale response is swallowed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmo_cnt <= 16'h0;
      r_drop    <= 1'b0;
    end else begin
      if (r_state == A_REQ) begin
        r_tmo_cnt <= 16'h0;
      end else if (r_state == D_WAIT) begin
        r_tmo_cnt <= r_tmo_cnt + 16'h1;
      end
      if (r_state == D_WAIT && !tl_i.d_valid && r_tmo_cnt == 16'hFFFF) begin
        r_drop <= 1'b1;
      end else if (r_state == IDLE && (tl_i.d_valid || req_i)) begin
        r_drop <= 1'b0;
      end
    end
  end

  logic w_timeout;
  assign w_timeout = (r_tmo_cnt == 16'hFFFF);
`else
  logic w_timeout;
  assign w_drop    = 1'b0;
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_be    <= 4'h0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_rdata <= 32'h0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_i) begin
            r_we    <= we_i;
            r_addr  <= addr_i;
            r_wdata <= wdata_i;
            r_be    <= be_i;
            r_state <= w_misaligned ? LOCAL_ERR : A_REQ;
          end
        end
        A_REQ: begin
          if (tl_i.a_ready) r_state <= D_WAIT;
        end
        D_WAIT: begin
          if (tl_i.d_valid) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_err   <= w_rsp_err;
            r_rdata <= w_rsp_err ? 32'hFFFF_FFFF : (r_we ? r_rdata : tl_i.d_data);
          end else if (w_timeout) begin
            r_state <= RESP;
            r_valid <= 1'b1;
            r_err   <= 1'b1;
            r_rdata <= 32'hFFFF_FFFF;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        LOCAL_ERR: begin
          r_state <= RESP;
          r_valid <= 1'b1;
          r_err   <= 1'b1;
          r_rdata <= 32'hFFFF_FFFF;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlul_simple_host.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tlul_simple_host : scoreboard bench driving a scripted TL-UL device.     |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_tlul_simple_host;

  localparam logic [7:0] SRC = 8'h5A;

  logic              clk = 1'b0;
  logic              rst_ni = 1'b0;
  logic              req_i = 1'b0;
  logic              we_i = 1'b0;
  logic [31:0]       addr_i = 32'h0;
  logic [31:0]       wdata_i = 32'h0;
  logic [3:0]        be_i = 4'h0;
  logic              gnt_o, valid_o, err_o, busy_o;
  logic [31:0]       rdata_o;
  tlul_pkg::tl_h2d_t tl_o;
  tlul_pkg::tl_d2h_t tl_i;

  tlul_simple_host #(.SourceId(SRC), .AddrAlignCheck(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
    .addr_i(addr_i), .we_i(we_i), .wdata_i(wdata_i), .be_i(be_i),
    .valid_o(valid_o), .rdata_o(rdata_o), .err_o(err_o), .busy_o(busy_o),
    .tl_o(tl_o), .tl_i(tl_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_mis = 0;
  int   n_hs = 0;
  int   exp_hs = 0;
  int   n_valid = 0;
  logic last_valid = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_intg(input logic [63:0] d);
    logic [6:0] r;
    r = 7'h0;
    for (int i = 0; i < 64; i++) begin
      if (((d >> i) & 64'd1) != 64'd0) r = r ^ (7'd1 << (i % 7));
    end
    return ~r;
  endfunction

  always @(posedge clk) begin
    if (rst_ni && tl_o.a_valid && tl_i.a_ready) n_hs++;
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_ni && valid_o) begin
      n_valid++;
      if (last_valid) check_val("valid_one_cycle", 1, 0);
      if (sb.size() == 0) begin
        check_val("unexpected_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check_val("resp_err", err_o, e.err);
        if (e.chk_rd) check_val("resp_rdata", rdata_o, e.rdata);
      end
    end
    last_valid = rst_ni && valid_o;
  end

  task automatic drive_rsp(input logic [2:0] dop, input logic [7:0] dsrc, input logic derr,
                           input logic [31:0] rd, input logic bad_intg);
    tl_i.d_opcode = dop;
    tl_i.d_size   = 2'd2;
    tl_i.d_source = dsrc;
    tl_i.d_error  = derr;
    tl_i.d_data   = rd;
    tl_i.d_user.rsp_intg  = ref_intg({58'b0, dop, 2'd2, derr}) ^ {6'b0, bad_intg};
    tl_i.d_user.data_intg = ref_intg({32'b0, rd});
    tl_i.d_valid  = 1'b1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic we, input logic [31:0] wd,
                       input logic [3:0] be, input int ardy_dly, input int d_dly,
                       input logic [31:0] rd, input logic [7:0] dsrc, input logic derr,
                       input logic bad_intg, input logic [2:0] dop, input logic poke_resp,
                       input logic noise);
    logic              e;
    logic [2:0]        xop;
    logic [3:0]        xmask;
    logic [31:0]       xdata;
    tlul_pkg::tl_h2d_t snap;
    @(negedge clk);
    addr_i = addr; we_i = we; wdata_i = wd; be_i = be; req_i = 1'b1;
    #1 check_val("gnt", gnt_o, 1);
    check_val("busy_idle", busy_o, 0);
    @(negedge clk);
    req_i = 1'b0;
    check_val("busy", busy_o, 1);
    if (addr[1:0] != 2'b00) begin
      sb.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
      check_val("mis_a_valid", tl_o.a_valid, 0);
      repeat (2) begin
        @(negedge clk);
        check_val("mis_a_valid", tl_o.a_valid, 0);
      end
      check_val("busy_end", busy_o, 0);
      return;
    end
    xop   = !we ? 3'h4 : (be == 4'hF ? 3'h0 : 3'h1);
    xmask = we ? be : 4'hF;
    xdata = we ? wd : 32'h0;
    check_val("a_valid", tl_o.a_valid, 1);
    check_val("a_opcode", tl_o.a_opcode, xop);
    check_val("a_mask", tl_o.a_mask, xmask);
    check_val("a_data", tl_o.a_data, xdata);
    check_val("a_address", tl_o.a_address, {addr[31:2], 2'b00});
    check_val("a_source", tl_o.a_source, SRC);
    check_val("a_size", tl_o.a_size, 2);
    check_val("a_cmd_intg", tl_o.a_user.cmd_intg, ref_intg({25'b0, xop, xmask, addr[31:2], 2'b00}));
    check_val("a_data_intg", tl_o.a_user.data_intg, ref_intg({32'b0, xdata}));
    check_val("d_ready_areq", tl_o.d_ready, 0);
    snap = tl_o;
    tl_i.a_ready = 1'b0;
    repeat (ardy_dly) begin
      if (noise) drive_rsp(3'h1, SRC, 1'b0, 32'h5555_AAAA, 1'b0);
      @(negedge clk);
      check_val("a_stable", tl_o == snap, 1);
    end
    tl_i.d_valid = 1'b0;
    tl_i.a_ready = 1'b1;
    exp_hs++;
    @(negedge clk);
    tl_i.a_ready = 1'b0;
    check_val("a_valid_drop", tl_o.a_valid, 0);
    check_val("d_ready", tl_o.d_ready, 1);
    repeat (d_dly) @(negedge clk);
    e = derr | (dsrc != SRC) | (dop != (we ? 3'h0 : 3'h1)) | bad_intg;
    sb.push_back('{e, e ? 32'hFFFF_FFFF : rd, e | !we});
    drive_rsp(dop, dsrc, derr, rd, bad_intg);
    @(negedge clk);
    tl_i.d_valid = 1'b0;
    check_val("busy_resp", busy_o, 1);
    if (poke_resp) begin
      req_i = 1'b1;
      #1 check_val("gnt_in_resp", gnt_o, 0);
      #1 req_i = 1'b0;
    end
    @(negedge clk);
    check_val("busy_end", busy_o, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int cnt;
    tl_i = '0;
    repeat (3) @(negedge clk);
    check_val("rst_gnt", gnt_o, 0);
    check_val("rst_valid", valid_o, 0);
    check_val("rst_rdata", rdata_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_busy", busy_o, 0);
    check_val("rst_a_valid", tl_o.a_valid, 0);
    check_val("rst_d_ready", tl_o.d_ready, 0);
    rst_ni = 1'b1;

    //     addr          we    wdata          be    ard dd  rdata          src      derr  bint  dop   poke  noise
    issue(32'h0000_0010, 1'b0, 32'h0,         4'h0, 0,  3, 32'hDEAD_BEEF, SRC,     1'b0, 1'b0, 3'h1, 1'b0, 1'b0);
    issue(32'h0000_0020, 1'b1, 32'h1234_5678, 4'h3, 0,  1, 32'h0,         SRC,     1'b0, 1'b0, 3'h0, 1'b0, 1'b0);
    issue(32'h0000_0024, 1'b1, 32'hA5A5_5A5A, 4'hF, 1,  0, 32'h0,         SRC,     1'b0, 1'b0, 3'h0, 1'b1, 1'b0);
    issue(32'h0000_0013, 1'b0, 32'h0,         4'h0, 0,  0, 32'h0,         SRC,     1'b0, 1'b0, 3'h1, 1'b0, 1'b0);
    issue(32'h0000_0030, 1'b0, 32'h0,         4'h0, 5,  0, 32'hCAFE_F00D, SRC,     1'b0, 1'b0, 3'h1, 1'b0, 1'b1);
    issue(32'h0000_0034, 1'b0, 32'h0,         4'h0, 0,  2, 32'h1111_2222, SRC + 1, 1'b0, 1'b0, 3'h1, 1'b0, 1'b0);
    issue(32'h0000_0038, 1'b1, 32'h0F0F_0F0F, 4'hC, 0,  0, 32'h0,         SRC,     1'b1, 1'b0, 3'h0, 1'b0, 1'b0);
    issue(32'h0000_003C, 1'b0, 32'h0,         4'h0, 0,  0, 32'h3333_4444, SRC,     1'b0, 1'b0, 3'h0, 1'b0, 1'b0);
    issue(32'h0000_0040, 1'b0, 32'h0,         4'h0, 2,  1, 32'h7777_8888, SRC,     1'b0, 1'b1, 3'h1, 1'b0, 1'b0);
    issue(32'h0000_0044, 1'b0, 32'h0,         4'h0, 0,  0, 32'h8765_4321, SRC,     1'b0, 1'b0, 3'h1, 1'b0, 1'b0);

    // Asynchronous reset while waiting on the D channel.
    nv = n_valid;
    @(negedge clk);
    addr_i = 32'h0000_0050; we_i = 1'b0; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    tl_i.a_ready = 1'b1;
    exp_hs++;
    @(negedge clk);
    tl_i.a_ready = 1'b0;
    check_val("rstmid_d_ready_pre", tl_o.d_ready, 1);
    #2 rst_ni = 1'b0;
    #1;
    check_val("rstmid_busy", busy_o, 0);
    check_val("rstmid_d_ready", tl_o.d_ready, 0);
    check_val("rstmid_a_valid", tl_o.a_valid, 0);
    check_val("rstmid_valid", valid_o, 0);
    check_val("rstmid_err", err_o, 0);
    check_val("rstmid_rdata", rdata_o, 0);
    @(negedge clk);
    rst_ni = 1'b1;
    drive_rsp(3'h1, SRC, 1'b0, 32'h9999_9999, 1'b0);
    @(negedge clk);
    tl_i.d_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rstmid_no_valid", n_valid, nv);
    check_val("rstmid_busy_after", busy_o, 0);

    issue(32'h0000_0060, 1'b0, 32'h0,         4'h0, 0,  0, 32'h0BAD_C0DE, SRC,     1'b0, 1'b0, 3'h1, 1'b0, 1'b0);

`ifdef TLUL_SIMPLE_HOST_TIMEOUT_EN
    @(negedge clk);
    addr_i = 32'h0000_0070; we_i = 1'b0; req_i = 1'b1;
    @(negedge clk);
    req_i = 1'b0;
    tl_i.a_ready = 1'b1;
    exp_hs++;
    @(negedge clk);
    tl_i.a_ready = 1'b0;
    sb.push_back('{1'b1, 32'hFFFF_FFFF, 1'b1});
    cnt = 0;
    while (!valid_o && cnt < 70000) begin
      @(negedge clk);
      cnt++;
    end
    check_val("tmo_fired", valid_o, 1);
    check_val("tmo_cycles", (cnt >= 65535 && cnt <= 65537), 1);
    @(negedge clk);
    check_val("tmo_drop_ready", tl_o.d_ready, 1);
    nv = n_valid;
    drive_rsp(3'h1, SRC, 1'b0, 32'h4444_4444, 1'b0);
    @(negedge clk);
    tl_i.d_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_val("tmo_drop_done", tl_o.d_ready, 0);
    check_val("tmo_no_valid", n_valid, nv);
`endif

    repeat (2) @(negedge clk);
    check_val("handshakes", n_hs, exp_hs);
    check_val("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
